// File: rtl/alien_fleet_ctrl_if.sv
// Bullet-hit kill handshake and per-pixel "alien here" query between the
// playfield logic and the fleet controller.
interface alien_fleet_ctrl_if #(
    parameter int ROWS = 3,
    parameter int COLS = 8
);
    logic                      hit_req;
    logic [$clog2(ROWS)-1:0]   hit_row;
    logic [$clog2(COLS)-1:0]   hit_col;
    logic                      hit_ack;
    logic                      hit_kill;
    logic [9:0]                pix_x;
    logic [9:0]                pix_y;
    logic                      alien_on;

    modport master (
        output hit_req, hit_row, hit_col, pix_x, pix_y,
        input  hit_ack, hit_kill, alien_on
    );

    modport slave (
        input  hit_req, hit_row, hit_col, pix_x, pix_y,
        output hit_ack, hit_kill, alien_on
    );
endinterface

// File: rtl/alien_fleet_ctrl.sv
// Alien formation sequencer: march scheduling with frame-aligned commits,
// kill handshake, and a registered per-pixel occupancy query.
module alien_fleet_ctrl #(
    parameter int ROWS       = 3,
    parameter int COLS       = 8,
    parameter int CELL_W     = 32,
    parameter int CELL_H     = 32,
    parameter int SPR_W      = 16,
    parameter int SPR_H      = 16,
    parameter int STEP_X     = 4,
    parameter int STEP_Y     = 8,
    parameter int STEP_TICKS = 30,
    parameter int X_START    = 208,
    parameter int Y_START    = 71,
    parameter int X_MIN      = 144,
    parameter int X_MAX      = 784,
    parameter int Y_LIMIT    = 471
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   game_tick,
    input  logic                   frame_start,
    input  logic                   start,
    alien_fleet_ctrl_if.slave      bus,
    output logic [9:0]             fleet_x,
    output logic [9:0]             fleet_y,
    output logic [ROWS*COLS-1:0]   alive,
    output logic                   dir_right,
    output logic                   all_dead,
    output logic                   landed
);
    localparam int N      = ROWS * COLS;
    localparam int IW     = $clog2(N);
    localparam int RW     = $clog2(ROWS);
    localparam int CLW    = $clog2(COLS);
    localparam int TW     = $clog2(STEP_TICKS);
    localparam int CW_LOG = $clog2(CELL_W);
    localparam int CH_LOG = $clog2(CELL_H);
    localparam int QCW    = 10 - CW_LOG;
    localparam int QRW    = 10 - CH_LOG;

    typedef enum logic [1:0] {IDLE, CHECK, PEND, HALT} state_t;

    state_t         state_reg, state_next;
    logic [9:0]     fx_reg, fy_reg, nx_reg, ny_reg;
    logic           dir_reg, ndir_reg;
    logic [RW-1:0]  nb_reg;
    logic [N-1:0]   alive_reg, alive_next;
    logic [TW-1:0]  tick_reg;
    logic           hit_ack_reg, hit_kill_reg, busy_reg, landed_reg, alien_on_reg;

    // Column/row occupancy of the bitmap.
    logic [N-1:0]    alive_t;
    logic [COLS-1:0] col_any;
    logic [ROWS-1:0] row_any;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        assign row_any[gi] = |alive_reg[gi*COLS +: COLS];
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            assign alive_t[gj*ROWS+gi] = alive_reg[gi*COLS+gj];
        end
    end

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col_any
        assign col_any[gi] = |alive_t[gi*ROWS +: ROWS];
    end

    logic [CLW-1:0] l_col, r_col;
    logic [RW-1:0]  b_row;

    always_comb begin
        l_col = '0;
        r_col = '0;
        b_row = '0;
        for (int c = COLS-1; c >= 0; c--) if (col_any[c]) l_col = CLW'(c);
        for (int c = 0; c < COLS; c++)    if (col_any[c]) r_col = CLW'(c);
        for (int r = 0; r < ROWS; r++)    if (row_any[r]) b_row = RW'(r);
    end

    logic [10:0] right_edge, left_edge, land_sum;
    logic        descend, landing;
    logic [9:0]  nx_calc, ny_calc;
    logic        ndir_calc;

    always_comb begin
        right_edge = {1'b0, fx_reg} + (11'(r_col) << CW_LOG) + 11'(SPR_W) + 11'(STEP_X);
        left_edge  = {1'b0, fx_reg} + (11'(l_col) << CW_LOG);
        descend    = dir_reg ? (right_edge > 11'(X_MAX)) : (left_edge < 11'(X_MIN + STEP_X));
        nx_calc    = descend ? fx_reg : (dir_reg ? fx_reg + 10'(STEP_X) : fx_reg - 10'(STEP_X));
        ny_calc    = descend ? fy_reg + 10'(STEP_Y) : fy_reg;
        ndir_calc  = descend ? ~dir_reg : dir_reg;
        land_sum   = {1'b0, ny_reg} + (11'(nb_reg) << CH_LOG) + 11'(SPR_H);
        landing    = land_sum >= 11'(Y_LIMIT);
    end

    logic step_due, commit;
    assign step_due = game_tick && (state_reg != HALT) && (tick_reg == TW'(STEP_TICKS - 1));
    assign all_dead = ~|alive_reg;

    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE:  if (all_dead || landed_reg) state_next = HALT;
                   else if (step_due)          state_next = CHECK;
            CHECK: state_next = PEND;
            PEND:  if (frame_start) begin
                       commit     = 1'b1;
                       state_next = IDLE;
                   end
            default: state_next = HALT;
        endcase
    end

    // busy_reg tracks the previous hit_req so one held request is served once.
    logic          accept, kill_next, idx_ok;
    logic [IW-1:0] hit_idx;

    always_comb begin
        hit_idx    = IW'(bus.hit_row) * IW'(COLS) + IW'(bus.hit_col);
        idx_ok     = hit_idx < IW'(N);
        accept     = bus.hit_req && !busy_reg;
        alive_next = alive_reg;
        kill_next  = 1'b0;
        if (accept && state_reg != HALT && idx_ok) begin
            kill_next           = alive_reg[hit_idx];
            alive_next[hit_idx] = 1'b0;
        end
    end

    logic [9:0]     dx, dy, q_idx;
    logic [QCW-1:0] q_col;
    logic [QRW-1:0] q_row;
    logic           q_in, on_next;

    always_comb begin
        dx      = bus.pix_x - fx_reg;
        dy      = bus.pix_y - fy_reg;
        q_col   = dx[9:CW_LOG];
        q_row   = dy[9:CH_LOG];
        q_in    = (bus.pix_x >= fx_reg) && (bus.pix_y >= fy_reg) &&
                  (q_col < QCW'(COLS)) && (q_row < QRW'(ROWS)) &&
                  (dx[CW_LOG-1:0] < CW_LOG'(SPR_W)) && (dy[CH_LOG-1:0] < CH_LOG'(SPR_H));
        q_idx   = 10'(q_row) * 10'(COLS) + 10'(q_col);
        on_next = q_in && (q_idx < 10'(N)) && alive_reg[q_idx[IW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            fx_reg       <= 10'(X_START);
            fy_reg       <= 10'(Y_START);
            dir_reg      <= 1'b1;
            alive_reg    <= '1;
            tick_reg     <= '0;
            nx_reg       <= '0;
            ny_reg       <= '0;
            ndir_reg     <= 1'b0;
            nb_reg       <= '0;
            hit_ack_reg  <= 1'b0;
            hit_kill_reg <= 1'b0;
            busy_reg     <= 1'b0;
            landed_reg   <= 1'b0;
            alien_on_reg <= 1'b0;
        end else if (start) begin
            state_reg    <= IDLE;
            fx_reg       <= 10'(X_START);
            fy_reg       <= 10'(Y_START);
            dir_reg      <= 1'b1;
            alive_reg    <= '1;
            tick_reg     <= '0;
            hit_ack_reg  <= 1'b0;
            hit_kill_reg <= 1'b0;
            busy_reg     <= 1'b0;
            landed_reg   <= 1'b0;
            alien_on_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (game_tick && state_reg != HALT)
                tick_reg <= step_due ? '0 : tick_reg + TW'(1);
            if (state_reg == CHECK) begin
                nx_reg   <= nx_calc;
                ny_reg   <= ny_calc;
                ndir_reg <= ndir_calc;
                nb_reg   <= b_row;
            end
            if (commit) begin
                fx_reg     <= nx_reg;
                fy_reg     <= ny_reg;
                dir_reg    <= ndir_reg;
                landed_reg <= landed_reg | landing;
            end
            alive_reg    <= alive_next;
            hit_ack_reg  <= accept;
            hit_kill_reg <= kill_next;
            busy_reg     <= bus.hit_req;
            alien_on_reg <= on_next;
        end
    end

    assign fleet_x      = fx_reg;
    assign fleet_y      = fy_reg;
    assign dir_right    = dir_reg;
    assign alive        = alive_reg;
    assign landed       = landed_reg;
    assign bus.hit_ack  = hit_ack_reg;
    assign bus.hit_kill = hit_kill_reg;
    assign bus.alien_on = alien_on_reg;
endmodule
